// File: rtl/de0_nios2_gen2_0_cpu_ocimem_ctrl.sv
// On-chip debug memory controller: runs JTAG debug-slave commands against the
// debug RAM and shares that RAM with a CPU-side Avalon-MM slave.
module de0_nios2_gen2_0_cpu_ocimem_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [ADDR_W-1:0] av_address,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [31:0]       av_writedata,
    input  logic [3:0]        av_byteenable,
    output logic [31:0]       av_readdata,
    output logic              av_waitrequest,
    output logic [ADDR_W-1:0] MonAReg,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, J_RD, J_CAP, A_RD} state_t;
    typedef enum logic [1:0] {CMD_NONE, CMD_A, CMD_B, CMD_NA} cmd_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] mon_a_reg, mon_a_next;
    logic [31:0]       mon_d_reg, mon_d_next;
    logic [31:0]       av_rdata_reg, av_rdata_next;
    logic              ready_reg, ready_next;
    logic              error_reg, error_next;
    logic              pend_valid_reg, pend_valid_next;
    cmd_t              pend_cmd_reg, pend_cmd_next;
    logic [37:0]       pend_jdo_reg, pend_jdo_next;

    cmd_t              strobe_cmd;
    logic              strobe_multi;
    cmd_t              exec_cmd;
    logic [37:0]       exec_jdo;
    logic              drop;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [3:0]        ram_be;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_q;

    // Only the command field bits of jdo matter to this block.
    logic unused_jdo_bits;
    assign unused_jdo_bits = &{1'b0, jdo[37:36], jdo[2:0]};

    // One byte-wide RAM per lane so byte enables map onto independent arrays.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] q_reg;
            always_ff @(posedge clk) begin
                if (ram_we && ram_be[gi]) begin
                    mem[ram_addr] <= ram_wdata[gi*8 +: 8];
                end
                q_reg <= mem[ram_addr];
            end
            assign ram_q[gi*8 +: 8] = q_reg;
        end
    endgenerate

    always_comb begin
        strobe_cmd = CMD_NONE;
        if (take_action_ocimem_a) begin
            strobe_cmd = CMD_A;
        end else if (take_action_ocimem_b) begin
            strobe_cmd = CMD_B;
        end else if (take_no_action_ocimem_a) begin
            strobe_cmd = CMD_NA;
        end
        strobe_multi = (take_action_ocimem_a & (take_action_ocimem_b | take_no_action_ocimem_a))
                     | (take_action_ocimem_b & take_no_action_ocimem_a);
    end

    always_comb begin
        state_next      = state_reg;
        mon_a_next      = mon_a_reg;
        mon_d_next      = mon_d_reg;
        av_rdata_next   = av_rdata_reg;
        ready_next      = ready_reg;
        error_next      = error_reg;
        pend_valid_next = pend_valid_reg;
        pend_cmd_next   = pend_cmd_reg;
        pend_jdo_next   = pend_jdo_reg;
        ram_addr        = mon_a_reg;
        ram_we          = 1'b0;
        ram_be          = 4'hF;
        ram_wdata       = jdo[34:3];
        av_waitrequest  = 1'b0;
        exec_cmd        = CMD_NONE;
        exec_jdo        = jdo;
        drop            = strobe_multi;

        case (state_reg)
            IDLE: begin
                if (pend_valid_reg) begin
                    // Slot is consumed now, so a fresh strobe may refill it.
                    exec_cmd        = pend_cmd_reg;
                    exec_jdo        = pend_jdo_reg;
                    pend_valid_next = (strobe_cmd != CMD_NONE);
                    pend_cmd_next   = strobe_cmd;
                    pend_jdo_next   = jdo;
                end else begin
                    exec_cmd = strobe_cmd;
                end

                if (exec_cmd != CMD_NONE) begin
                    av_waitrequest = av_read | av_write;
                end else if (av_write) begin
                    ram_we    = 1'b1;
                    ram_addr  = av_address;
                    ram_wdata = av_writedata;
                    ram_be    = av_byteenable;
                end else if (av_read) begin
                    av_waitrequest = 1'b1;
                    ram_addr       = av_address;
                    state_next     = A_RD;
                end
            end
            J_RD: begin
                av_waitrequest = av_read | av_write;
                drop           = drop | (strobe_cmd != CMD_NONE);
                state_next     = J_CAP;
            end
            J_CAP: begin
                av_waitrequest = av_read | av_write;
                drop           = drop | (strobe_cmd != CMD_NONE);
                mon_d_next     = ram_q;
                ready_next     = 1'b1;
                mon_a_next     = mon_a_reg + ADDR_W'(1);
                state_next     = IDLE;
            end
            A_RD: begin
                av_rdata_next = ram_q;
                state_next    = IDLE;
                if (strobe_cmd != CMD_NONE) begin
                    if (pend_valid_reg) begin
                        drop = 1'b1;
                    end else begin
                        pend_valid_next = 1'b1;
                        pend_cmd_next   = strobe_cmd;
                        pend_jdo_next   = jdo;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        case (exec_cmd)
            CMD_A: begin
                mon_a_next = exec_jdo[ADDR_W+9:10];
                ready_next = 1'b0;
                if (exec_jdo[35]) begin
                    error_next = 1'b0;
                end
                if (exec_jdo[34]) begin
                    state_next = J_RD;
                end
            end
            CMD_B: begin
                ram_we     = 1'b1;
                ram_addr   = mon_a_reg;
                ram_be     = 4'hF;
                ram_wdata  = exec_jdo[34:3];
                mon_a_next = mon_a_reg + ADDR_W'(1);
                ready_next = 1'b0;
            end
            CMD_NA: begin
                ready_next = 1'b0;
                state_next = J_RD;
            end
            default: ;
        endcase

        // A dropped strobe is the newer event, so it wins over a clear.
        if (drop) begin
            error_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            mon_a_reg      <= '0;
            mon_d_reg      <= '0;
            av_rdata_reg   <= '0;
            ready_reg      <= 1'b0;
            error_reg      <= 1'b0;
            pend_valid_reg <= 1'b0;
            pend_cmd_reg   <= CMD_NONE;
            pend_jdo_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            mon_a_reg      <= mon_a_next;
            mon_d_reg      <= mon_d_next;
            av_rdata_reg   <= av_rdata_next;
            ready_reg      <= ready_next;
            error_reg      <= error_next;
            pend_valid_reg <= pend_valid_next;
            pend_cmd_reg   <= pend_cmd_next;
            pend_jdo_reg   <= pend_jdo_next;
        end
    end

    assign MonAReg       = mon_a_reg;
    assign MonDReg       = mon_d_reg;
    assign monitor_ready = ready_reg;
    assign monitor_error = error_reg;
    assign av_readdata   = av_rdata_reg;

endmodule

// File: tb/tb_de0_nios2_gen2_0_cpu_ocimem_ctrl.sv
// Self-checking bench for the debug memory controller: directed scenarios plus
// randomized traffic checked against a word-array memory model.
module tb_de0_nios2_gen2_0_cpu_ocimem_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [37:0] jdo = '0;
    logic        take_action_ocimem_a = 1'b0;
    logic        take_action_ocimem_b = 1'b0;
    logic        take_no_action_ocimem_a = 1'b0;
    logic [7:0]  av_address = '0;
    logic        av_read = 1'b0;
    logic        av_write = 1'b0;
    logic [31:0] av_writedata = '0;
    logic [3:0]  av_byteenable = '0;
    logic [31:0] av_readdata;
    logic        av_waitrequest;
    logic [7:0]  MonAReg;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: memory words, JTAG address pointer, last read word.
    logic [31:0] m_mem [256];
    logic [7:0]  m_addr = '0;
    logic [31:0] m_dreg = '0;

    de0_nios2_gen2_0_cpu_ocimem_ctrl #(.ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .jdo(jdo),
        .take_action_ocimem_a(take_action_ocimem_a),
        .take_action_ocimem_b(take_action_ocimem_b),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .av_address(av_address), .av_read(av_read), .av_write(av_write),
        .av_writedata(av_writedata), .av_byteenable(av_byteenable),
        .av_readdata(av_readdata), .av_waitrequest(av_waitrequest),
        .MonAReg(MonAReg), .MonDReg(MonDReg),
        .monitor_ready(monitor_ready), .monitor_error(monitor_error)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] rand_jdo();
        logic [37:0] j;
        j[31:0]  = $urandom();
        j[37:32] = 6'($urandom());
        return j;
    endfunction

    function automatic logic [37:0] jdo_a(input logic [7:0] addr, input logic rd, input logic clr);
        logic [37:0] j;
        j = rand_jdo();
        j[17:10] = addr;
        j[34] = rd;
        j[35] = clr;
        return j;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] data);
        logic [37:0] j;
        j = rand_jdo();
        j[34:3] = data;
        return j;
    endfunction

    // One-cycle strobe; the edge inside samples it.
    task automatic pulse(input logic a, input logic b, input logic na, input logic [37:0] j);
        take_action_ocimem_a = a;
        take_action_ocimem_b = b;
        take_no_action_ocimem_a = na;
        jdo = j;
        tick();
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        jdo = rand_jdo();
        $display("txn jtag a=%0b b=%0b na=%0b jdo=%h", a, b, na, j);
    endtask

    task automatic jtag_load(input logic [7:0] addr, input logic clr);
        pulse(1'b1, 1'b0, 1'b0, jdo_a(addr, 1'b0, clr));
        m_addr = addr;
    endtask

    task automatic jtag_write(input logic [31:0] data);
        pulse(1'b0, 1'b1, 1'b0, jdo_b(data));
        m_mem[m_addr] = data;
        m_addr = m_addr + 8'd1;
    endtask

    // Full read: strobe edge plus two more edges until MonDReg is fresh.
    task automatic jtag_read(input logic use_na, input logic [7:0] addr);
        if (use_na) pulse(1'b0, 1'b0, 1'b1, rand_jdo());
        else begin
            pulse(1'b1, 1'b0, 1'b0, jdo_a(addr, 1'b1, 1'b0));
            m_addr = addr;
        end
        tick();
        tick();
        m_dreg = m_mem[m_addr];
        m_addr = m_addr + 8'd1;
    endtask

    task automatic av_write_op(input logic [7:0] addr, input logic [31:0] data,
                               input logic [3:0] be, output logic wait_seen);
        av_write = 1'b1;
        av_address = addr;
        av_writedata = data;
        av_byteenable = be;
        @(negedge clk);
        wait_seen = av_waitrequest;
        tick();
        av_write = 1'b0;
        for (int k = 0; k < 4; k++) if (be[k]) m_mem[addr][k*8 +: 8] = data[k*8 +: 8];
        $display("txn av_write addr=%h data=%h be=%h", addr, data, be);
    endtask

    task automatic av_read_op(input logic [7:0] addr, output logic [31:0] data, output int waits);
        bit done = 0;
        av_read = 1'b1;
        av_address = addr;
        waits = 0;
        for (int c = 0; c < 10 && !done; c++) begin
            @(negedge clk);
            if (av_waitrequest) waits++;
            else done = 1;
            tick();
        end
        av_read = 1'b0;
        data = av_readdata;
        if (!done) waits = -1;
        $display("txn av_read addr=%h data=%h waits=%0d", addr, data, waits);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        n_total++; if (MonAReg !== 8'h00) $display("FAIL reset_MonAReg: got %h want 00", MonAReg); else n_pass++;
        n_total++; if (MonDReg !== 32'h0) $display("FAIL reset_MonDReg: got %h want 0", MonDReg); else n_pass++;
        n_total++; if (monitor_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", monitor_ready); else n_pass++;
        n_total++; if (monitor_error !== 1'b0) $display("FAIL reset_error: got %b want 0", monitor_error); else n_pass++;
        n_total++; if (av_readdata !== 32'h0) $display("FAIL reset_readdata: got %h want 0", av_readdata); else n_pass++;
        n_total++; if (av_waitrequest !== 1'b0) $display("FAIL reset_waitreq: got %b want 0", av_waitrequest); else n_pass++;
    endtask

    task automatic test_fill();
        logic w;
        for (int i = 0; i < 256; i++) begin
            av_write_op(8'(i), $urandom(), 4'hF, w);
            n_total++; if (w !== 1'b0) $display("FAIL fill_waitreq[%0d]: got %b want 0", i, w); else n_pass++;
        end
    endtask

    task automatic test_addr_load();
        jtag_load(8'h10, 1'b0);
        n_total++; if (MonAReg !== 8'h10) $display("FAIL addr_load: MonAReg got %h want 10", MonAReg); else n_pass++;
        n_total++; if (monitor_ready !== 1'b0) $display("FAIL addr_load_ready: got %b want 0", monitor_ready); else n_pass++;
    endtask

    task automatic test_jtag_write();
        jtag_write(32'hDEADBEEF);
        jtag_write(32'h1);
        jtag_write(32'h2);
        n_total++; if (MonAReg !== 8'h13) $display("FAIL jtag_write_addr: got %h want 13", MonAReg); else n_pass++;
        n_total++; if (monitor_ready !== 1'b0) $display("FAIL jtag_write_ready: got %b want 0", monitor_ready); else n_pass++;
    endtask

    task automatic test_jtag_read();
        pulse(1'b1, 1'b0, 1'b0, jdo_a(8'h10, 1'b1, 1'b0));
        n_total++; if (monitor_ready !== 1'b0) $display("FAIL read_ready_e0: got %b want 0", monitor_ready); else n_pass++;
        tick();
        n_total++; if (monitor_ready !== 1'b0) $display("FAIL read_ready_e1: got %b want 0", monitor_ready); else n_pass++;
        tick();
        n_total++; if (monitor_ready !== 1'b1) $display("FAIL read_ready_e2: got %b want 1", monitor_ready); else n_pass++;
        n_total++; if (MonDReg !== 32'hDEADBEEF) $display("FAIL read_data0: got %h want deadbeef", MonDReg); else n_pass++;
        n_total++; if (MonAReg !== 8'h11) $display("FAIL read_addr0: got %h want 11", MonAReg); else n_pass++;
        m_addr = 8'h11;
        pulse(1'b0, 1'b0, 1'b1, rand_jdo());
        n_total++; if (monitor_ready !== 1'b0) $display("FAIL na_ready_clear: got %b want 0", monitor_ready); else n_pass++;
        tick();
        tick();
        m_dreg = m_mem[8'h11];
        m_addr = 8'h12;
        n_total++; if (MonDReg !== 32'h1) $display("FAIL na_data: got %h want 1", MonDReg); else n_pass++;
        n_total++; if (MonAReg !== 8'h12) $display("FAIL na_addr: got %h want 12", MonAReg); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [31:0] d = $urandom();
        jtag_load(8'hFF, 1'b0);
        jtag_write(d);
        n_total++; if (MonAReg !== 8'h00) $display("FAIL wrap_write_addr: got %h want 00", MonAReg); else n_pass++;
        jtag_read(1'b0, 8'hFF);
        n_total++; if (MonDReg !== d) $display("FAIL wrap_data: got %h want %h", MonDReg, d); else n_pass++;
        n_total++; if (MonAReg !== 8'h00) $display("FAIL wrap_read_addr: got %h want 00", MonAReg); else n_pass++;
    endtask

    task automatic test_avalon_pending();
        jtag_load(8'h10, 1'b0);
        av_read = 1'b1;
        av_address = 8'h12;
        @(negedge clk);
        n_total++; if (av_waitrequest !== 1'b1) $display("FAIL pend_wait_idle: got %b want 1", av_waitrequest); else n_pass++;
        tick();
        take_no_action_ocimem_a = 1'b1;
        @(negedge clk);
        n_total++; if (av_waitrequest !== 1'b0) $display("FAIL pend_wait_ard: got %b want 0", av_waitrequest); else n_pass++;
        tick();
        av_read = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        $display("txn av_read addr=12 with jtag read strobe in A_RD");
        n_total++; if (av_readdata !== 32'h2) $display("FAIL pend_readdata: got %h want 2", av_readdata); else n_pass++;
        tick();
        tick();
        tick();
        m_dreg = m_mem[8'h10];
        m_addr = 8'h11;
        n_total++; if (monitor_ready !== 1'b1) $display("FAIL pend_ready: got %b want 1", monitor_ready); else n_pass++;
        n_total++; if (MonDReg !== m_dreg) $display("FAIL pend_data: got %h want %h", MonDReg, m_dreg); else n_pass++;
        n_total++; if (MonAReg !== 8'h11) $display("FAIL pend_addr: got %h want 11", MonAReg); else n_pass++;
        n_total++; if (monitor_error !== 1'b0) $display("FAIL pend_error: got %b want 0", monitor_error); else n_pass++;
    endtask

    task automatic test_overrun();
        logic [31:0] rd;
        int waits;
        pulse(1'b1, 1'b0, 1'b0, jdo_a(8'h20, 1'b1, 1'b0));
        pulse(1'b0, 1'b1, 1'b0, jdo_b(~m_mem[8'h20]));
        tick();
        m_dreg = m_mem[8'h20];
        m_addr = 8'h21;
        n_total++; if (monitor_error !== 1'b1) $display("FAIL overrun_error: got %b want 1", monitor_error); else n_pass++;
        n_total++; if (MonDReg !== m_dreg) $display("FAIL overrun_data: got %h want %h", MonDReg, m_dreg); else n_pass++;
        n_total++; if (MonAReg !== 8'h21) $display("FAIL overrun_addr: got %h want 21", MonAReg); else n_pass++;
        av_read_op(8'h20, rd, waits);
        n_total++; if (rd !== m_mem[8'h20]) $display("FAIL overrun_nowrite: got %h want %h", rd, m_mem[8'h20]); else n_pass++;
        jtag_load(8'h21, 1'b1);
        n_total++; if (monitor_error !== 1'b0) $display("FAIL overrun_clear: got %b want 0", monitor_error); else n_pass++;
    endtask

    task automatic test_multi_strobe();
        logic [7:0] old = m_addr;
        logic [31:0] rd;
        int waits;
        pulse(1'b1, 1'b1, 1'b0, jdo_a(8'h40, 1'b0, 1'b0));
        m_addr = 8'h40;
        n_total++; if (MonAReg !== 8'h40) $display("FAIL multi_addr: got %h want 40", MonAReg); else n_pass++;
        n_total++; if (monitor_error !== 1'b1) $display("FAIL multi_error: got %b want 1", monitor_error); else n_pass++;
        av_read_op(old, rd, waits);
        n_total++; if (rd !== m_mem[old]) $display("FAIL multi_nowrite: got %h want %h", rd, m_mem[old]); else n_pass++;
        jtag_load(8'h40, 1'b1);
        n_total++; if (monitor_error !== 1'b0) $display("FAIL multi_clear: got %b want 0", monitor_error); else n_pass++;
    endtask

    task automatic test_byteenable();
        logic [3:0] be_list [4] = '{4'h3, 4'hC, 4'h5, 4'h0};
        logic [31:0] rd;
        logic w;
        int waits;
        foreach (be_list[i]) begin
            av_write_op(8'h20, $urandom(), be_list[i], w);
            n_total++; if (w !== 1'b0) $display("FAIL be_waitreq[%0d]: got %b want 0", i, w); else n_pass++;
            av_read_op(8'h20, rd, waits);
            n_total++; if (rd !== m_mem[8'h20]) $display("FAIL be_data[%0d]: got %h want %h", i, rd, m_mem[8'h20]); else n_pass++;
            n_total++; if (waits != 1) $display("FAIL be_waits[%0d]: got %0d want 1", i, waits); else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [31:0] rd;
        logic w;
        int waits;
        logic [7:0] a;
        for (int i = 0; i < 150; i++) begin
            a = 8'($urandom());
            case ($urandom_range(0, 4))
                0: begin
                    av_write_op(a, $urandom(), 4'($urandom()), w);
                    n_total++; if (w !== 1'b0) $display("FAIL rnd_wr_wait[%0d]: got %b want 0", i, w); else n_pass++;
                end
                1: begin
                    av_read_op(a, rd, waits);
                    n_total++; if (rd !== m_mem[a] || waits != 1) $display("FAIL rnd_rd[%0d]: got %h/%0d want %h/1", i, rd, waits, m_mem[a]); else n_pass++;
                end
                2: jtag_write($urandom());
                3: begin
                    jtag_read(1'($urandom()), a);
                    n_total++; if (MonDReg !== m_dreg || monitor_ready !== 1'b1) $display("FAIL rnd_jrd[%0d]: got %h/%b want %h/1", i, MonDReg, monitor_ready, m_dreg); else n_pass++;
                end
                default: jtag_load(a, 1'b0);
            endcase
            n_total++; if (MonAReg !== m_addr) $display("FAIL rnd_addr[%0d]: got %h want %h", i, MonAReg, m_addr); else n_pass++;
        end
        n_total++; if (monitor_error !== 1'b0) $display("FAIL rnd_error: got %b want 0", monitor_error); else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        pulse(1'b1, 1'b0, 1'b0, jdo_a(8'h30, 1'b1, 1'b0));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_addr = 8'h00;
        m_dreg = 32'h0;
        n_total++; if (MonAReg !== m_addr) $display("FAIL midrd_addr: got %h want 00", MonAReg); else n_pass++;
        tick();
        tick();
        n_total++; if (monitor_ready !== 1'b0) $display("FAIL midrd_ready: got %b want 0", monitor_ready); else n_pass++;
        n_total++; if (MonDReg !== m_dreg) $display("FAIL midrd_data: got %h want 0", MonDReg); else n_pass++;
        n_total++; if (MonAReg !== m_addr) $display("FAIL midrd_addr_after: got %h want 00", MonAReg); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_addr_load();
        test_jtag_write();
        test_jtag_read();
        test_wrap();
        test_avalon_pending();
        test_overrun();
        test_multi_strobe();
        test_byteenable();
        test_random();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
